// File: rtl/microwave_cook_ctrl.sv
// Cook-cycle sequencer for the microwave oven.
// Takes debounced button pulses and the door switch, tracks remaining cook
// time in seconds and counts it down once per tick. All outputs are registered.
//
// Inputs btn_* are one-cycle pulses and need no handshake. door_open is a level.
// Only the highest-priority event in a cycle acts: btn_stop > door_open > btn_start > add.
// door_open acts only in COOK, where it pauses, and in DONE, where its rising edge ends the beep.
// In every other state an open door simply blocks btn_start.
// An ignored btn_start still masks a same-cycle add.
module microwave_cook_ctrl #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int MAX_SEC   = 5999,
  parameter int QUICK_SEC = 30,
  parameter int BEEP_SEC  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_start,
  input  logic        btn_stop,
  input  logic        btn_add_min,
  input  logic        btn_add_10s,
  input  logic        door_open,
  output logic        motor_enable,
  output logic        heater_on,
  output logic        done_beep,
  output logic [12:0] remain_sec,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BEEP_SEC > 1) ? $clog2(BEEP_SEC) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_SEC - 1);
  localparam logic [12:0]   MAX_V     = 13'(MAX_SEC);
  localparam logic [12:0]   QUICK_V   = 13'(QUICK_SEC);

  state_t          state_q, state_d;
  logic [12:0]     remain_d;
  logic [12:0]     cook_val;
  logic [TW-1:0]   tick_cnt;
  logic [BW-1:0]   beep_cnt;
  logic            door_q;
  logic            tick;
  logic            add_any;
  logic            any_btn;
  logic            door_rise;
  logic [6:0]      add_amt;
  logic [13:0]     add_sum;
  logic [12:0]     add_sat;

  // Event decode and the saturating add shared by all states that accept adds
  always_comb begin
    tick      = (tick_cnt == TICK_LAST);
    add_any   = btn_add_min | btn_add_10s;
    any_btn   = btn_start | btn_stop | add_any;
    door_rise = door_open & ~door_q;
    add_amt   = (btn_add_min ? 7'd60 : 7'd0) + (btn_add_10s ? 7'd10 : 7'd0);
    add_sum   = {1'b0, remain_sec} + 14'(add_amt);
    add_sat   = (add_sum > 14'(MAX_SEC)) ? MAX_V : add_sum[12:0];
  end

  // Next-state and next remaining-time logic
  always_comb begin
    state_d  = state_q;
    remain_d = remain_sec;
    cook_val = remain_sec;
    unique case (state_q)
      ST_IDLE: begin
        if (btn_stop) begin
          remain_d = '0;
        end else if (btn_start) begin
          if (!door_open) begin
            remain_d = QUICK_V;
            state_d  = ST_COOK;
          end
        end else if (add_any) begin
          remain_d = add_sat;
          state_d  = ST_SET;
        end
      end
      ST_SET, ST_PAUSE: begin
        if (btn_stop) begin
          remain_d = '0;
          state_d  = ST_IDLE;
        end else if (btn_start) begin
          if (!door_open) state_d = ST_COOK;
        end else if (add_any) begin
          remain_d = add_sat;
        end
      end
      ST_COOK: begin
        if (btn_stop || door_open) begin
          state_d = ST_PAUSE;
        end else begin
          // An add landing on a tick is applied before the decrement
          if (!btn_start && add_any) cook_val = add_sat;
          remain_d = cook_val;
          if (tick && cook_val != 13'd0) begin
            remain_d = cook_val - 13'd1;
            if (cook_val == 13'd1) state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        remain_d = '0;
        if (any_btn || door_rise) state_d = ST_IDLE;
        else if (tick && beep_cnt == BEEP_LAST) state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        remain_d = '0;
      end
    endcase
  end

  // State register and registered outputs; reset drops everything at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      remain_sec   <= '0;
      motor_enable <= 1'b0;
      heater_on    <= 1'b0;
      done_beep    <= 1'b0;
      door_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      remain_sec   <= remain_d;
      motor_enable <= (state_d == ST_COOK);
      heater_on    <= (state_d == ST_COOK);
      done_beep    <= (state_d == ST_DONE);
      door_q       <= door_open;
    end
  end

  // Tick prescaler: restarts on every state change so a paused partial tick is lost
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (state_d != state_q) begin
      tick_cnt <= '0;
    end else if (state_q == ST_COOK || state_q == ST_DONE) begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end else begin
      tick_cnt <= '0;
    end
  end

  // Beep duration counter, in ticks spent in DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beep_cnt <= '0;
    end else if (state_d != state_q) begin
      beep_cnt <= '0;
    end else if (state_q == ST_DONE && tick) begin
      beep_cnt <= beep_cnt + 1'b1;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_microwave_cook_ctrl.sv
// Bench for microwave_cook_ctrl: directed scenarios plus random button/door
// traffic, compared every cycle against a behavioural model of the cook rules.
module tb_microwave_cook_ctrl;

  localparam int TD    = 10;
  localparam int MAXS  = 5999;
  localparam int QUICK = 30;
  localparam int BEEP  = 3;

  localparam int S_IDLE = 0, S_SET = 1, S_COOK = 2, S_PAUSE = 3, S_DONE = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        btn_start = 1'b0, btn_stop = 1'b0, btn_add_min = 1'b0, btn_add_10s = 1'b0;
  logic        door_open = 1'b0;
  logic        motor_enable, heater_on, done_beep;
  logic [12:0] remain_sec;
  logic [2:0]  state;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mode, seconds left, cycles spent in the current mode
  int m_state = S_IDLE;
  int m_remain = 0;
  int m_seg = 0;
  bit m_door_prev = 0;

  microwave_cook_ctrl #(.TICK_DIV(TD), .MAX_SEC(MAXS), .QUICK_SEC(QUICK), .BEEP_SEC(BEEP)) dut (
    .clk(clk), .reset(reset),
    .btn_start(btn_start), .btn_stop(btn_stop),
    .btn_add_min(btn_add_min), .btn_add_10s(btn_add_10s),
    .door_open(door_open),
    .motor_enable(motor_enable), .heater_on(heater_on), .done_beep(done_beep),
    .remain_sec(remain_sec), .state(state)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat_add(input int a, input int b);
    return (a + b > MAXS) ? MAXS : a + b;
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_remain = 0; m_seg = 0; m_door_prev = 0;
  endtask

  // One clock of the cook rules, from the inputs seen this cycle
  task automatic model_step(input bit stp, input bit sta, input bit am, input bit a10, input bit dr);
    int add = (am ? 60 : 0) + (a10 ? 10 : 0);
    int ns = m_state;
    int nr = m_remain;
    bit ticking = (m_seg % TD) == TD - 1;
    case (m_state)
      S_IDLE: begin
        if (stp) nr = 0;
        else if (sta) begin
          if (!dr) begin nr = QUICK; ns = S_COOK; end
        end else if (add > 0) begin nr = sat_add(m_remain, add); ns = S_SET; end
      end
      S_SET, S_PAUSE: begin
        if (stp) begin nr = 0; ns = S_IDLE; end
        else if (sta) begin
          if (!dr) ns = S_COOK;
        end else if (add > 0) nr = sat_add(m_remain, add);
      end
      S_COOK: begin
        if (stp || dr) ns = S_PAUSE;
        else begin
          if (!sta && add > 0) nr = sat_add(m_remain, add);
          if (ticking) begin
            nr = nr - 1;
            if (nr == 0) ns = S_DONE;
          end
        end
      end
      S_DONE: begin
        nr = 0;
        if (stp || sta || am || a10 || (dr && !m_door_prev)) ns = S_IDLE;
        else if (m_seg == BEEP * TD - 1) ns = S_IDLE;
      end
      default: ns = S_IDLE;
    endcase
    m_seg = (ns != m_state) ? 0 : m_seg + 1;
    m_state = ns;
    m_remain = nr;
    m_door_prev = dr;
  endtask

  task automatic check_outputs(input string tag);
    bit ck = (m_state == S_COOK);
    bit dn = (m_state == S_DONE);
    check({tag, ".state"}, 32'(state), 32'(m_state));
    check({tag, ".remain"}, 32'(remain_sec), 32'(m_remain));
    check({tag, ".outs"}, {29'd0, motor_enable, heater_on, done_beep}, {29'd0, ck, ck, dn});
  endtask

  // Driver: apply one cycle of inputs, advance model, check after the edge
  task automatic step(input bit stp, input bit sta, input bit am, input bit a10, input bit dr);
    @(negedge clk);
    btn_stop = stp; btn_start = sta; btn_add_min = am; btn_add_10s = a10; door_open = dr;
    model_step(stp, sta, am, a10, dr);
    @(posedge clk);
    #1;
    btn_stop = 0; btn_start = 0; btn_add_min = 0; btn_add_10s = 0;
    check_outputs("cyc");
  endtask

  task automatic idle_steps(input int n, input bit dr);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, dr);
  endtask

  initial begin
    bit rdoor;
    // Reset
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    reset = 1'b1;

    // Two +10 s, then start: SET then COOK, count down to DONE, beep, IDLE
    step(0, 0, 0, 1, 0);
    check("add1_state", 32'(state), S_SET);
    step(0, 0, 0, 1, 0);
    check("add2_remain", 32'(remain_sec), 20);
    step(0, 1, 0, 0, 0);
    check("start_motor", 32'(motor_enable), 1);
    idle_steps(9, 0);
    check("pre_tick", 32'(remain_sec), 20);
    step(0, 0, 0, 0, 0);
    check("first_tick", 32'(remain_sec), 19);
    idle_steps(189, 0);
    check("last_sec", 32'(remain_sec), 1);
    step(0, 0, 0, 0, 0);
    check("done_state", 32'(state), S_DONE);
    check("done_beep", 32'(done_beep), 1);
    idle_steps(29, 0);
    check("beep_hold", 32'(done_beep), 1);
    step(0, 0, 0, 0, 0);
    check("after_beep", 32'(state), S_IDLE);
    check("after_motor", 32'(motor_enable), 0);

    // Quick start blocked by open door, then accepted
    step(0, 1, 0, 0, 1);
    check("qs_door", 32'(state), S_IDLE);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    check("qs_remain", 32'(remain_sec), QUICK);

    // Door opened mid-cook at 15 s, resume gives a full tick before decrement
    idle_steps(150, 0);
    check("at15", 32'(remain_sec), 15);
    idle_steps(3, 0);
    step(0, 0, 0, 0, 1);
    check("door_pause", 32'(state), S_PAUSE);
    check("door_motor", 32'(motor_enable), 0);
    idle_steps(2, 1);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    idle_steps(9, 0);
    check("resume_hold", 32'(remain_sec), 15);
    step(0, 0, 0, 0, 0);
    check("resume_tick", 32'(remain_sec), 14);

    // Stop+start together: COOK -> PAUSE, PAUSE -> IDLE with time cleared
    step(1, 1, 0, 0, 0);
    check("prio_cook", 32'(state), S_PAUSE);
    step(1, 1, 0, 0, 0);
    check("prio_pause", 32'(state), S_IDLE);
    check("prio_clear", 32'(remain_sec), 0);

    // Saturation at 99:59
    for (int i = 0; i < 100; i++) step(0, 0, 1, 0, 0);
    check("sat_min", 32'(remain_sec), MAXS);
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    check("sat_10s", 32'(remain_sec), MAXS);
    step(1, 0, 0, 0, 0);

    // Asynchronous reset mid-cook
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    idle_steps(4, 0);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("areset_motor", 32'(motor_enable), 0);
    check("areset_heater", 32'(heater_on), 0);
    check("areset_remain", 32'(remain_sec), 0);
    check("areset_state", 32'(state), S_IDLE);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle_steps(15, 0);
    check("areset_stay", 32'(state), S_IDLE);

    // Random traffic against the model
    rdoor = 0;
    for (int i = 0; i < 3000; i++) begin
      bit stp, sta, am, a10;
      if ($urandom_range(0, 29) == 0) rdoor = ~rdoor;
      stp = ($urandom_range(0, 39) == 0);
      sta = ($urandom_range(0, 9) == 0);
      am  = ($urandom_range(0, 79) == 0);
      a10 = ($urandom_range(0, 14) == 0);
      step(stp, sta, am, a10, rdoor);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
